regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (addrw/wdata/we) between two writeback requesters:

---
 rtl/regfile_wb_arbiter_pkg.sv | 36 +++
 rtl/regfile_wb_starve_ctr.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback constants and helpers. The regfile and the hazard unit use the same
// hardwired-register definitions.
package regfile_wb_arbiter_pkg;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam logic [4:0]  REG_ONE        = 5'd1;
    localparam logic [4:0]  REG_PC         = 5'd31;
    localparam logic [31:0] HARDWIRED_MASK = 32'h8000_0003;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EX   = 2'd1,
        GNT_LD   = 2'd2
    } grant_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    function automatic logic is_hardwired(input logic [4:0] addr);
        return (addr == REG_ZERO) || (addr == REG_ONE) || (addr == REG_PC);
    endfunction

    function automatic logic [31:0] decode_mask(input logic [4:0] addr, input logic en);
        logic [31:0] m;
        m = 32'd0;
        if (en) begin
            m[addr] = 1'b1;
        end else begin
            m = 32'd0;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_starve_ctr.sv
// Saturating count of consecutive cycles the EX requester was refused; raises force_o once
// EX has waited MAX_WAIT cycles so the arbiter lets it through.
module regfile_wb_starve_ctr #(
    parameter int MAX_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_valid_i,
    input  logic ex_ready_i,
    output logic force_o
);

    localparam int              WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0] wait_q;
    logic [WW-1:0] wait_d;

    // Next wait value: count refusals, clear on transfer or idle EX.
    always_comb begin
        wait_d = wait_q;
        if (ex_valid_i && !ex_ready_i) begin
            if (wait_q == WAIT_MAX) begin
                wait_d = wait_q;
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end else begin
            wait_d = {WW{1'b0}};
        end
    end

    // Wait register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= {WW{1'b0}};
        end else begin
            wait_q <= wait_d;
        end
    end

    assign force_o = (wait_q == WAIT_MAX);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between EX results and returning loads (LD wins
// by default, EX is forced through after MAX_WAIT refusals) and exports a pending-write bitmap.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [4:0]       ex_addr,
    input  logic [31:0]      ex_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             hold,
    output logic             rf_we,
    output logic [4:0]       rf_addrw,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] dropped
);

    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    grant_e           grant_s;
    wb_req_t          win_s;
    logic             xfer_s;
    logic             force_s;

    logic             we_q,      we_d;
    logic [4:0]       addrw_q,   addrw_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    regfile_wb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .ex_valid_i (ex_valid),
        .ex_ready_i (ex_ready),
        .force_o    (force_s)
    );

    // Grant selection: LD priority unless EX has starved long enough.
    always_comb begin
        grant_s = GNT_NONE;
        if (rst || hold) begin
            grant_s = GNT_NONE;
        end else if (ex_valid && ld_valid) begin
            grant_s = force_s ? GNT_EX : GNT_LD;
        end else if (ex_valid) begin
            grant_s = GNT_EX;
        end else if (ld_valid) begin
            grant_s = GNT_LD;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    assign ex_ready = (grant_s == GNT_EX);
    assign ld_ready = (grant_s == GNT_LD);
    assign xfer_s   = (grant_s != GNT_NONE);

    // Winning request mux.
    always_comb begin
        win_s = '{addr: 5'd0, data: 32'd0};
        case (grant_s)
            GNT_EX:  win_s = '{addr: ex_addr, data: ex_data};
            GNT_LD:  win_s = '{addr: ld_addr, data: ld_data};
            default: win_s = '{addr: 5'd0, data: 32'd0};
        endcase
    end

    // Next output-register state; hardwired targets are swallowed and counted instead.
    always_comb begin
        we_d      = 1'b0;
        addrw_d   = addrw_q;
        wdata_d   = wdata_q;
        dropped_d = dropped_q;
        if (xfer_s) begin
            if (is_hardwired(win_s.addr)) begin
                if (dropped_q != CNT_ONES) begin
                    dropped_d = dropped_q + CNT_W'(1);
                end else begin
                    dropped_d = dropped_q;
                end
            end else begin
                we_d    = 1'b1;
                addrw_d = win_s.addr;
                wdata_d = win_s.data;
            end
        end else begin
            we_d = 1'b0;
        end
    end

    // Output and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            addrw_q   <= 5'd0;
            wdata_q   <= 32'd0;
            dropped_q <= {CNT_W{1'b0}};
        end else begin
            we_q      <= we_d;
            addrw_q   <= addrw_d;
            wdata_q   <= wdata_d;
            dropped_q <= dropped_d;
        end
    end

    // Masking with rst discards a write already in flight when reset lands mid-operation.
    assign rf_we    = we_q & ~rst;
    assign rf_addrw = rst ? 5'd0 : addrw_q;
    assign rf_wdata = rst ? 32'd0 : wdata_q;
    assign dropped  = rst ? {CNT_W{1'b0}} : dropped_q;

    assign pending = (decode_mask(ex_addr, ex_valid)
                    | decode_mask(ld_addr, ld_valid)
                    | decode_mask(rf_addrw, rf_we)) & ~HARDWIRED_MASK;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: the driver queues expected regfile writes and checks
// ready/pending; an independent monitor pops and compares every rf_we pulse.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        hold;
    logic        rf_we;
    logic [4:0]  rf_addrw;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic [15:0] dropped;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          pchk = 1'b0;
    logic [31:0] exp_pend = 32'd0;
    bit          rchk = 1'b0;

    regfile_wb_arbiter #(
        .MAX_WAIT (3),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_addr  (ex_addr),
        .ex_data  (ex_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .hold     (hold),
        .rf_we    (rf_we),
        .rf_addrw (rf_addrw),
        .rf_wdata (rf_wdata),
        .pending  (pending),
        .dropped  (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // wr: 0 = no regfile write expected, 1 = EX write, 2 = LD write
    task automatic cyc(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                       input logic h, input logic r,
                       input logic er, input logic lr, input int wr);
        exp_t e;
        ex_valid = ev; ex_addr = ea; ex_data = ed;
        ld_valid = lv; ld_addr = la; ld_data = ldd;
        hold = h; rst = r;
        #2;
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, er});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, lr});
        if (pchk) begin
            chk("pending", pending, exp_pend);
            pchk = 1'b0;
        end
        if (rchk) begin
            chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
            chk("rst_rf_addrw", {27'd0, rf_addrw}, 32'd0);
            chk("rst_rf_wdata", rf_wdata, 32'd0);
            chk("rst_dropped", {16'd0, dropped}, 32'd0);
            rchk = 1'b0;
        end
        if (wr == 1) begin
            e.a = ea; e.d = ed; exp_q.push_back(e);
        end else if (wr == 2) begin
            e.a = la; e.d = ldd; exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                         rf_addrw, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_addrw !== mon_e.a || rf_wdata !== mon_e.d) begin
                    n_bad++;
                    $display("FAIL rf_write: got addr %0d data %h expected addr %0d data %h",
                             rf_addrw, rf_wdata, mon_e.a, mon_e.d);
                end
            end
        end else if (rf_we !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rf_we_x: got %b expected 0/1", rf_we);
        end
    end

    initial begin
        rst = 1'b1; hold = 1'b0;
        ex_valid = 1'b0; ex_addr = 5'd0; ex_data = 32'd0;
        ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;

        // Reset: requests refused, outputs at reset values
        rchk = 1'b1;
        cyc(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        rchk = 1'b1;
        cyc(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // EX only
        pchk = 1'b1; exp_pend = 32'h0000_0020;
        cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // Both valid: LD x3, then EX forced, then remaining LD
        pchk = 1'b1; exp_pend = 32'h0000_0C20;
        cyc(1'b1, 5'd10, 32'hE10, 1'b1, 5'd11, 32'hD11, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        cyc(1'b1, 5'd10, 32'hE10, 1'b1, 5'd12, 32'hD12, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        cyc(1'b1, 5'd10, 32'hE10, 1'b1, 5'd13, 32'hD13, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        cyc(1'b1, 5'd10, 32'hE10, 1'b1, 5'd14, 32'hD14, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        cyc(1'b0, 5'd0,  32'd0,   1'b1, 5'd14, 32'hD14, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Hardwired targets: accepted, no write, counted
        pchk = 1'b1; exp_pend = 32'h0000_4000;
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        pchk = 1'b1; exp_pend = 32'h0000_0000;
        cyc(1'b1, 5'd31, 32'hBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        idle();
        chk("dropped_2", {16'd0, dropped}, 32'd2);

        // Hold 5 cycles with both valid; EX wins once released
        pchk = 1'b1; exp_pend = 32'h0030_0000;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 5'd20, 32'hE20, 1'b1, 5'd21, 32'hD21, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end
        cyc(1'b1, 5'd20, 32'hE20, 1'b1, 5'd21, 32'hD21, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        cyc(1'b0, 5'd0,  32'd0,   1'b1, 5'd21, 32'hD21, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Same destination from both ports: LD first, EX last
        pchk = 1'b1; exp_pend = 32'h0020_0200;
        cyc(1'b1, 5'd9, 32'hE9, 1'b1, 5'd9, 32'hD9, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        pchk = 1'b1; exp_pend = 32'h0000_0200;
        cyc(1'b1, 5'd9, 32'hE9, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        pchk = 1'b1; exp_pend = 32'h0000_0200;
        idle();
        chk("r9_final_data", rf_wdata, 32'hE9);
        pchk = 1'b1; exp_pend = 32'h0000_0000;
        idle();

        // Reset right after an accepted EX write: the write never reaches the regfile
        cyc(1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        rchk = 1'b1;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle();
        chk("post_rst_dropped", {16'd0, dropped}, 32'd0);
        chk("post_rst_addrw", {27'd0, rf_addrw}, 32'd0);

        // Recovery after reset
        cyc(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
